// File: rtl/regfile_client_dumper.sv
// regfile_client_dumper: reads a range of registers through the register
// file's client read port. Each word goes out as an (address, data) pair on a
// valid/ready handshake. Only one word is in flight at a time, and the block
// only reads the register file.
//
// Ports:
//   Clk, Rst    - clock; synchronous active-high reset
//   Start       - dump request, sampled only in IDLE
//   FirstAddr   - first register index of the dump
//   Count       - number of registers to dump (0 means 2**ADDR_W)
//   ClientAddr  - client read address to the register file
//   ClientData  - combinational client read data from the register file
//   OutAddr     - register index of the presented word
//   OutData     - register value of the presented word
//   OutValid    - OutAddr/OutData valid
//   OutReady    - downstream accepts when OutValid && OutReady
//   Busy        - dump in progress
//   Done        - one-cycle pulse after the last word is accepted
module regfile_client_dumper #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W-1:0] FirstAddr,
    input  logic [ADDR_W:0]   Count,
    output logic [ADDR_W-1:0] ClientAddr,
    input  logic [DATA_W-1:0] ClientData,
    output logic [ADDR_W-1:0] OutAddr,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    // Count of 0 encodes a full sweep of every register.
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1) << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   remaining_q;
    logic [CNT_W-1:0]   remaining_d;
    logic [ADDR_W-1:0]  client_addr_d;
    logic [ADDR_W-1:0]  out_addr_d;
    logic [DATA_W-1:0]  out_data_d;
    logic               out_valid_d;
    logic               busy_d;
    logic               done_d;
    logic               accept;
    logic               last_word;

    assign accept    = OutValid && OutReady;
    assign last_word = (remaining_q == CNT_W'(1));

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = FETCH;
            FETCH:   state_d = SEND;
            SEND:    if (accept) state_d = last_word ? FIN : FETCH;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and the remaining-word counter.
    always_comb begin
        client_addr_d = ClientAddr;
        out_addr_d    = OutAddr;
        out_data_d    = OutData;
        out_valid_d   = OutValid;
        busy_d        = Busy;
        done_d        = 1'b0;
        remaining_d   = remaining_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    client_addr_d = FirstAddr;
                    remaining_d   = (Count == '0) ? FULL_CNT : Count;
                    busy_d        = 1'b1;
                end
            end
            FETCH: begin
                // ClientAddr has been stable for a full cycle, so sample the word.
                out_data_d  = ClientData;
                out_addr_d  = ClientAddr;
                out_valid_d = 1'b1;
            end
            SEND: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (last_word) begin
                        done_d = 1'b1;
                    end else begin
                        // Address wraps silently at the top of the register file.
                        client_addr_d = ClientAddr + ADDR_W'(1);
                    end
                end
            end
            FIN: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Registered outputs. Reset drops any word that is in flight.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ClientAddr  <= '0;
            OutAddr     <= '0;
            OutData     <= '0;
            OutValid    <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            remaining_q <= '0;
        end else begin
            ClientAddr  <= client_addr_d;
            OutAddr     <= out_addr_d;
            OutData     <= out_data_d;
            OutValid    <= out_valid_d;
            Busy        <= busy_d;
            Done        <= done_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_regfile_client_dumper.sv
// Directed testbench for regfile_client_dumper with a behavioural register file.
module tb_regfile_client_dumper;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [4:0]  FirstAddr = '0;
    logic [5:0]  Count = '0;
    logic [4:0]  ClientAddr;
    logic [31:0] ClientData;
    logic [4:0]  OutAddr;
    logic [31:0] OutData;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic        Busy;
    logic        Done;

    logic [31:0] regs [32];

    int checks = 0;
    int errors = 0;

    assign ClientData = regs[ClientAddr];

    regfile_client_dumper #(.ADDR_W(5), .DATA_W(32)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .FirstAddr  (FirstAddr),
        .Count      (Count),
        .ClientAddr (ClientAddr),
        .ClientData (ClientData),
        .OutAddr    (OutAddr),
        .OutData    (OutData),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; sample #1 after the rising edge.
    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    // Wait (bounded) for a word, check it, then let the accepting edge pass.
    task automatic expect_word(input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        while (!OutValid && n < 8) begin
            cycle();
            n++;
        end
        check("word_valid", 32'(OutValid), 32'd1);
        check("word_addr", 32'(OutAddr), 32'(a));
        check("word_data", OutData, d);
        cycle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] a;
        for (int i = 0; i < 32; i++) regs[i] = '0;

        // Reset then idle
        cycle();
        cycle();
        check("rst_client_addr", 32'(ClientAddr), 32'd0);
        check("rst_out_addr", 32'(OutAddr), 32'd0);
        check("rst_out_data", OutData, 32'd0);
        check("rst_valid", 32'(OutValid), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("idle_valid", 32'(OutValid), 32'd0);
            check("idle_busy", 32'(Busy), 32'd0);
        end

        // Basic dump: regs 4,5,6 with full cycle-by-cycle timing
        regs[1] = 32'hD8;
        regs[5] = 32'h9A;
        OutReady = 1'b1;
        Start = 1'b1; FirstAddr = 5'd4; Count = 6'd3;
        cycle();
        Start = 1'b0;
        check("b_e0_client_addr", 32'(ClientAddr), 32'd4);
        check("b_e0_busy", 32'(Busy), 32'd1);
        check("b_e0_valid", 32'(OutValid), 32'd0);
        cycle();
        check("b_w0_valid", 32'(OutValid), 32'd1);
        check("b_w0_addr", 32'(OutAddr), 32'd4);
        check("b_w0_data", OutData, 32'h0);
        cycle();
        check("b_gap0_valid", 32'(OutValid), 32'd0);
        check("b_gap0_client_addr", 32'(ClientAddr), 32'd5);
        cycle();
        check("b_w1_valid", 32'(OutValid), 32'd1);
        check("b_w1_addr", 32'(OutAddr), 32'd5);
        check("b_w1_data", OutData, 32'h9A);
        cycle();
        check("b_gap1_valid", 32'(OutValid), 32'd0);
        cycle();
        check("b_w2_valid", 32'(OutValid), 32'd1);
        check("b_w2_addr", 32'(OutAddr), 32'd6);
        check("b_w2_data", OutData, 32'h0);
        check("b_w2_done", 32'(Done), 32'd0);
        cycle();
        check("b_fin_done", 32'(Done), 32'd1);
        check("b_fin_busy", 32'(Busy), 32'd1);
        check("b_fin_valid", 32'(OutValid), 32'd0);
        cycle();
        check("b_end_done", 32'(Done), 32'd0);
        check("b_end_busy", 32'(Busy), 32'd0);

        // Backpressure on the second word; snapshot ignores a later write
        Start = 1'b1; FirstAddr = 5'd4; Count = 6'd3;
        cycle();
        Start = 1'b0;
        cycle();
        check("bp_w0_addr", 32'(OutAddr), 32'd4);
        cycle();
        OutReady = 1'b0;
        cycle();
        check("bp_w1_valid", 32'(OutValid), 32'd1);
        regs[5] = 32'h1234;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_hold_valid", 32'(OutValid), 32'd1);
            check("bp_hold_addr", 32'(OutAddr), 32'd5);
            check("bp_hold_data", OutData, 32'h9A);
        end
        regs[5] = 32'h9A;
        OutReady = 1'b1;
        cycle();
        check("bp_acc_valid", 32'(OutValid), 32'd0);
        cycle();
        check("bp_w2_addr", 32'(OutAddr), 32'd6);
        check("bp_w2_valid", 32'(OutValid), 32'd1);
        cycle();
        check("bp_done", 32'(Done), 32'd1);
        cycle();
        check("bp_idle_busy", 32'(Busy), 32'd0);

        // Wrap and full count: 32 words starting at 30
        for (int i = 1; i < 32; i++) regs[i] = 32'h100 + 32'(i);
        Start = 1'b1; FirstAddr = 5'd30; Count = 6'd0;
        cycle();
        Start = 1'b0;
        for (int w = 0; w < 32; w++) begin
            a = 5'(30 + w);
            check("wrap_done_early", 32'(Done), 32'd0);
            expect_word(a, (a == 5'd0) ? 32'h0 : 32'h100 + 32'(a));
        end
        check("wrap_done", 32'(Done), 32'd1);
        cycle();
        check("wrap_idle_busy", 32'(Busy), 32'd0);
        check("wrap_idle_valid", 32'(OutValid), 32'd0);

        // Start during Busy and during FIN is ignored
        Start = 1'b1; FirstAddr = 5'd4; Count = 6'd3;
        cycle();
        Start = 1'b0;
        expect_word(5'd4, 32'h104);
        Start = 1'b1; FirstAddr = 5'd10; Count = 6'd1;
        cycle();
        Start = 1'b0;
        expect_word(5'd5, 32'h105);
        expect_word(5'd6, 32'h106);
        check("sb_done", 32'(Done), 32'd1);
        Start = 1'b1; FirstAddr = 5'd10;
        cycle();
        Start = 1'b0;
        check("sb_fin_busy", 32'(Busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("sb_idle_valid", 32'(OutValid), 32'd0);
            check("sb_idle_busy", 32'(Busy), 32'd0);
        end

        // Reset mid-dump, then a fresh dump across the wrap
        OutReady = 1'b0;
        Start = 1'b1; FirstAddr = 5'd0; Count = 6'd4;
        cycle();
        Start = 1'b0;
        cycle();
        check("rm_valid", 32'(OutValid), 32'd1);
        Rst = 1'b1;
        cycle();
        Rst = 1'b0;
        check("rm_valid_after", 32'(OutValid), 32'd0);
        check("rm_busy_after", 32'(Busy), 32'd0);
        check("rm_client_addr", 32'(ClientAddr), 32'd0);
        check("rm_out_data", OutData, 32'd0);
        cycle();
        check("rm_idle_valid", 32'(OutValid), 32'd0);
        OutReady = 1'b1;
        Start = 1'b1; FirstAddr = 5'd31; Count = 6'd2;
        cycle();
        Start = 1'b0;
        expect_word(5'd31, 32'h11F);
        expect_word(5'd0, 32'h0);
        check("rm_done", 32'(Done), 32'd1);
        cycle();
        check("rm_end_busy", 32'(Busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_client_dumper.md
Name: regfile_client_dumper

Overview:
- Client-side reader for the register file's third (client) read port.
- Walks the client address through a requested range of registers and samples the returned data.
- Streams each word out as an (address, data) pair over a valid/ready handshake, e.g. toward a debug/UART bridge or a memory-mapped monitor.
- One word in flight; no side effects on the register file (read-only).

Parameters:
- ADDR_W, 5, register address width (DEPTH = 2**ADDR_W = 32 registers).
- DATA_W, 32, register data width.

Ports:
- Clk  input  1  system clock, all logic on rising edge.
- Rst  input  1  reset, synchronous, active-high.
- Start  input  1  request a dump; sampled only in IDLE.
- FirstAddr  input  ADDR_W  first register index of the dump.
- Count  input  ADDR_W+1  number of registers to dump (0 means 32).
- ClientAddr  output  ADDR_W  drives the register file client read address.
- ClientData  input  DATA_W  combinational client read data from the register file.
- OutAddr  output  ADDR_W  register index of the presented word.
- OutData  output  DATA_W  presented register value.
- OutValid  output  1  OutAddr/OutData valid.
- OutReady  input  1  downstream accepts the word when OutValid && OutReady.
- Busy  output  1  high from the cycle after Start is accepted until Done.
- Done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (Rst=1 at a Clk edge): state=IDLE, ClientAddr=0, OutAddr=0, OutData=0, OutValid=0, Busy=0, Done=0, internal remaining-count=0. Reset has priority over every other input, including mid-dump; any in-flight word is dropped.
- States: IDLE, FETCH, SEND, FIN.
- IDLE: if Start=1, latch FirstAddr into ClientAddr and the address pointer, latch Count (0→32) into remaining. Then go FETCH and set Busy=1. Otherwise stay.
- FETCH (one cycle; ClientAddr stable, register file output settles): at the edge, OutData<=ClientData, OutAddr<=ClientAddr, OutValid<=1, go SEND.
- SEND: hold OutValid/OutAddr/OutData stable while OutReady=0. On OutValid && OutReady at an edge: OutValid<=0, remaining<=remaining-1.
  - If remaining was 1: go FIN.
  - Otherwise: ClientAddr<=ClientAddr+1 (mod 32, wraps 31→0), go FETCH.
- FIN: Done=1 for exactly this cycle, Busy<=0, go IDLE. Done is registered: high in the cycle after the final handshake.
- Latency:
  - Start sampled at edge E0.
  - ClientAddr=FirstAddr from E0.
  - First OutValid=1 from edge E1.
  - Words are spaced at least 2 cycles apart (handshake edge → FETCH → valid).
- Snapshot semantics: data is the value on ClientData at the FETCH edge. Register writes after that edge are not reflected in the held word. The register file's same-cycle write bypass onto ClientData is captured if present at that edge.
- Register 0 always reads 0; this is a pass-through, not a special case.
- Start while Busy, or in FIN, is ignored (not queued).
- OutReady with OutValid=0 has no effect.
- Widths: remaining is ADDR_W+1 bits, so a 32-word dump is representable. The address increment is ADDR_W-bit and wraps silently.

Test Plan:
- Reset then idle: Rst=1 for 2 cycles, Start=0 → all outputs 0, Busy=0, no OutValid for 10 cycles.
- Basic dump: regs 1=0xD8, 5=0x9A (others 0). Start with FirstAddr=4, Count=3, OutReady=1 → three words (4,0x0), (5,0x9A), (6,0x0), each OutValid one cycle, 2 cycles apart. Done pulses one cycle after the third handshake; Busy spans exactly the dump.
- Backpressure: same as basic dump but OutReady=0 for 5 cycles on the second word → (5,0x9A) held stable for all 5 cycles. The next word is not emitted until after acceptance.
- Wrap and full count: FirstAddr=30, Count=0 → 32 words in order 30,31,0,1,…,29; OutAddr=0 has OutData=0; Done after the 32nd.
- Start during Busy: second Start pulse mid-dump with different FirstAddr → ignored; original sequence and word count unchanged.
- Reset mid-operation: Rst=1 while in SEND with OutValid=1 → next cycle OutValid=0, Busy=0, IDLE. A subsequent Start runs a fresh dump correctly.
